// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU with a small register bank and an iterative shift-add multiplier.
// Each instruction steps through READ, then EXEC or MUL, then WRITE before the next one is accepted.
module alu_multiciclo #(
  parameter int unsigned NBITS = 4,
  parameter int unsigned RLOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3+3*RLOG2-1:0] instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic [NBITS-1:0]     leds,
  output logic [NBITS-1:0]     result_hi,
  output logic [2:0]           flags,
  output logic                 done
);

  localparam int unsigned TAMINSTR = 3 + 3*RLOG2;
  localparam int unsigned NREGS    = 2**RLOG2;
  localparam int unsigned IMMW     = 2*RLOG2;
  localparam int unsigned CNTW     = $clog2(NBITS + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_MUL   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TAMINSTR-1:0]   r_instr;
  logic [NBITS-1:0]      r_bank [NREGS];
  logic [NBITS-1:0]      r_a;
  logic [NBITS-1:0]      r_b;
  logic [NBITS-1:0]      r_phi;
  logic [NBITS-1:0]      r_plo;
  logic [CNTW-1:0]       r_cnt;
  logic [NBITS-1:0]      r_leds;
  logic [NBITS-1:0]      r_hi;
  logic [2:0]            r_flags;
  logic                  r_done;
  logic                  r_ready;

  logic [2:0]            w_op;
  logic [RLOG2-1:0]      w_rd;
  logic [RLOG2-1:0]      w_ra;
  logic [RLOG2-1:0]      w_rb;
  logic [NBITS-1:0]      w_imm;
  logic [NBITS:0]        w_add;
  logic [NBITS:0]        w_sub;
  logic [NBITS:0]        w_mul_sum;
  logic [NBITS-1:0]      w_phi_nxt;
  logic [NBITS-1:0]      w_plo_nxt;
  logic                  w_mul_last;
  logic [NBITS-1:0]      w_res;
  logic [NBITS-1:0]      w_hi;
  logic                  w_c;
  logic                  w_v;

  assign w_op  = r_instr[TAMINSTR-1 -: 3];
  assign w_rd  = r_instr[3*RLOG2-1 -: RLOG2];
  assign w_ra  = r_instr[2*RLOG2-1 -: RLOG2];
  assign w_rb  = r_instr[RLOG2-1:0];
  assign w_imm = NBITS'(r_instr[IMMW-1:0]);

  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};

  // One shift-add step: multiplier sits in the low half and drains out as the product shifts in.
  assign w_mul_sum  = {1'b0, r_phi} + (r_plo[0] ? {1'b0, r_a} : {(NBITS+1){1'b0}});
  assign w_phi_nxt  = w_mul_sum[NBITS:1];
  assign w_plo_nxt  = {w_mul_sum[0], r_plo[NBITS-1:1]};
  assign w_mul_last = (r_cnt == CNTW'(NBITS - 1));

  always_comb begin
    w_res = '0;
    w_hi  = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_res = w_add[NBITS-1:0];
        w_c   = w_add[NBITS];
        w_v   = (r_a[NBITS-1] == r_b[NBITS-1]) && (w_add[NBITS-1] != r_a[NBITS-1]);
      end
      OP_SUB: begin
        w_res = w_sub[NBITS-1:0];
        w_c   = w_sub[NBITS];
        w_v   = (r_a[NBITS-1] != r_b[NBITS-1]) && (w_sub[NBITS-1] != r_a[NBITS-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_SHL: begin
        w_res = {r_a[NBITS-2:0], 1'b0};
        w_c   = r_a[NBITS-1];
      end
      OP_MUL: begin
        w_res = w_plo_nxt;
        w_hi  = w_phi_nxt;
        w_c   = |w_phi_nxt;
      end
      OP_LDI: w_res = w_imm;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = (w_op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC:  w_state_nxt = S_WRITE;
      S_MUL:   if (w_mul_last) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, multiply steps, result commit and bank writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_cnt   <= '0;
      r_leds  <= '0;
      r_hi    <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      for (int i = 0; i < NREGS; i++) r_bank[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (instr_valid) r_instr <= instr;
        S_READ: begin
          r_a   <= r_bank[w_ra];
          r_b   <= r_bank[w_rb];
          r_phi <= '0;
          r_plo <= r_bank[w_rb];
          r_cnt <= '0;
        end
        S_EXEC: begin
          r_leds  <= w_res;
          r_hi    <= w_hi;
          r_flags <= {~|w_res, w_c, w_v};
        end
        S_MUL: begin
          r_phi <= w_phi_nxt;
          r_plo <= w_plo_nxt;
          r_cnt <= r_cnt + CNTW'(1);
          if (w_mul_last) begin
            r_leds  <= w_res;
            r_hi    <= w_hi;
            r_flags <= {~|w_res, w_c, w_v};
          end
        end
        S_WRITE: r_bank[w_rd] <= r_leds;
        default: ;
      endcase
      r_ready <= (w_state_nxt == S_IDLE);
      r_done  <= (w_state_nxt == S_WRITE);
    end
  end

  assign instr_ready = r_ready;
  assign leds        = r_leds;
  assign result_hi   = r_hi;
  assign flags       = r_flags;
  assign done        = r_done;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Bench for alu_multiciclo: directed vector table, reset/back-to-back sequences,
// and random instructions checked against an arithmetic reference model.
module tb_alu_multiciclo;

  localparam int N    = 4;
  localparam int MOD  = 1 << N;
  localparam int HALF = 1 << (N - 1);
  localparam int NREG = 4;

  logic       clk;
  logic       reset;
  logic [8:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [N-1:0] leds;
  logic [N-1:0] result_hi;
  logic [2:0] flags;
  logic       done;

  int nerr = 0;
  int nchk = 0;
  int mbank [NREG];

  typedef struct {
    int lo;
    int hi;
    logic [2:0] fl;
  } res_t;

  typedef struct {
    logic [2:0] op;
    int rd;
    int ra;
    int rb;
    int lo;
    int hi;
    logic [2:0] fl;
  } vec_t;

  vec_t tbl [15];

  alu_multiciclo dut (
    .clk(clk),
    .reset(reset),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .leds(leds),
    .result_hi(result_hi),
    .flags(flags),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  // Reference model: plain integer arithmetic on the modelled bank.
  function automatic res_t model(input logic [2:0] op, input int ra, input int rb);
    res_t r;
    int a, b, s, ss;
    logic z, c, v;
    a = mbank[ra];
    b = mbank[rb];
    r.lo = 0;
    r.hi = 0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: begin
        s = a + b; r.lo = s % MOD; c = (s >= MOD);
        ss = to_signed(a) + to_signed(b); v = (ss >= HALF) || (ss < -HALF);
      end
      3'b001: begin
        s = a - b; r.lo = (s + MOD) % MOD; c = (a < b);
        ss = to_signed(a) - to_signed(b); v = (ss >= HALF) || (ss < -HALF);
      end
      3'b010: r.lo = a & b;
      3'b011: r.lo = a | b;
      3'b100: r.lo = a ^ b;
      3'b101: begin r.lo = (a * 2) % MOD; c = (a >= HALF); end
      3'b110: begin s = a * b; r.lo = s % MOD; r.hi = s / MOD; c = (r.hi != 0); end
      default: r.lo = (ra * NREG + rb) % MOD;
    endcase
    z = (r.lo == 0);
    r.fl = {z, c, v};
    return r;
  endfunction

  // Issue one instruction from IDLE and check latency, outputs and the return to IDLE.
  task automatic run_op(input logic [2:0] op, input int rd, input int ra, input int rb,
                        input int elo, input int ehi, input logic [2:0] efl, input string tag);
    int w, edges, rdy_seen, exp_lat;
    w = 0;
    while (!instr_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, "_ready_wait"}, int'(w < 50), 1);
    exp_lat = (op == 3'b110) ? 2 + N : 3;
    instr = {op, 2'(rd), 2'(ra), 2'(rb)};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = '0;
    edges = 1;
    rdy_seen = 0;
    while (!done && edges < 40) begin
      if (instr_ready) rdy_seen++;
      @(posedge clk); #1;
      edges++;
    end
    if (instr_ready) rdy_seen++;
    chk({tag, "_latency"}, edges, exp_lat);
    chk({tag, "_ready_low"}, rdy_seen, 0);
    chk({tag, "_leds"}, int'(leds), elo);
    chk({tag, "_hi"}, int'(result_hi), ehi);
    chk({tag, "_flags"}, int'(flags), int'(efl));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_ready_after"}, int'(instr_ready), 1);
    mbank[rd] = elo;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_leds"}, int'(leds), 0);
    chk({tag, "_hi"}, int'(result_hi), 0);
    chk({tag, "_flags"}, int'(flags), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ready"}, int'(instr_ready), 1);
  endtask

  // Hold instr_valid high over three queued instructions.
  task automatic back_to_back();
    logic [8:0] q [3];
    int lat [3];
    int idx, ndone, cyc, last_done;
    logic rdy;
    res_t r;
    q[0] = {3'b000, 2'd3, 2'd0, 2'd1};
    q[1] = {3'b110, 2'd2, 2'd3, 2'd1};
    q[2] = {3'b001, 2'd0, 2'd2, 2'd3};
    lat[0] = 3; lat[1] = 2 + N; lat[2] = 3;
    idx = 0; ndone = 0; cyc = 0; last_done = 0;
    instr = q[0];
    instr_valid = 1'b1;
    while (ndone < 3 && cyc < 100) begin
      rdy = instr_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy && instr_valid) begin
        idx++;
        if (idx < 3) instr = q[idx];
        else begin instr_valid = 1'b0; instr = '0; end
      end
      if (done) begin
        r = model(q[ndone][8:6], int'(q[ndone][3:2]), int'(q[ndone][1:0]));
        chk($sformatf("b2b%0d_leds", ndone), int'(leds), r.lo);
        chk($sformatf("b2b%0d_flags", ndone), int'(flags), int'(r.fl));
        mbank[int'(q[ndone][5:4])] = r.lo;
        if (ndone > 0) chk($sformatf("b2b%0d_spacing", ndone), cyc - last_done, lat[ndone] + 1);
        last_done = cyc;
        ndone++;
      end
    end
    instr_valid = 1'b0;
    chk("b2b_done_count", ndone, 3);
    chk("b2b_accept_count", idx, 3);
    @(posedge clk); #1;
    chk("b2b_idle", int'(instr_ready), 1);
  endtask

  initial begin
    res_t r;
    logic [2:0] op;
    int rd, ra, rb;

    tbl[0]  = '{3'b111, 0, 1, 3,  7,  0, 3'b000};
    tbl[1]  = '{3'b111, 1, 2, 1,  9,  0, 3'b000};
    tbl[2]  = '{3'b000, 2, 0, 1,  0,  0, 3'b110};
    tbl[3]  = '{3'b111, 1, 0, 1,  1,  0, 3'b000};
    tbl[4]  = '{3'b000, 0, 0, 1,  8,  0, 3'b001};
    tbl[5]  = '{3'b000, 3, 0, 2,  8,  0, 3'b000};
    tbl[6]  = '{3'b111, 0, 0, 3,  3,  0, 3'b000};
    tbl[7]  = '{3'b111, 1, 1, 1,  5,  0, 3'b000};
    tbl[8]  = '{3'b001, 2, 0, 1, 14,  0, 3'b010};
    tbl[9]  = '{3'b111, 0, 3, 3, 15,  0, 3'b000};
    tbl[10] = '{3'b111, 1, 3, 3, 15,  0, 3'b000};
    tbl[11] = '{3'b110, 2, 0, 1,  1, 14, 3'b010};
    tbl[12] = '{3'b010, 3, 0, 2,  1,  0, 3'b000};
    tbl[13] = '{3'b101, 3, 0, 2, 14,  0, 3'b010};
    tbl[14] = '{3'b100, 3, 0, 1,  0,  0, 3'b100};

    for (int i = 0; i < NREG; i++) mbank[i] = 0;
    reset = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb,
             tbl[i].lo, tbl[i].hi, tbl[i].fl, $sformatf("vec%0d", i));

    // Reset during the second MUL cycle must abort with no writeback.
    run_op(3'b111, 0, 3, 3, 15, 0, 3'b000, "pre_rst_ldi");
    instr = {3'b110, 2'd1, 2'd0, 2'd0};
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_outputs_zero("mul_abort");
    #2;
    reset = 1'b1;
    for (int i = 0; i < NREG; i++) mbank[i] = 0;
    @(posedge clk); #1;
    run_op(3'b000, 2, 1, 0, 0, 0, 3'b100, "post_rst_add");

    back_to_back();

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      rd = int'($urandom_range(0, NREG - 1));
      ra = int'($urandom_range(0, NREG - 1));
      rb = int'($urandom_range(0, NREG - 1));
      r = model(op, ra, rb);
      run_op(op, rd, ra, rb, r.lo, r.hi, r.fl, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
